// File: rtl/i2s_master_core.sv
// I2S clock-master transceiver core.
// Generates SCK/WS from clk_i through a programmable divider, serialises TX stream words onto
// i2s_sd_o and assembles i2s_sd_i into RX stream words. One word per WS half-frame; left first.
// Ports:
//   clk_i, rst_n_i           system clock, asynchronous active-low reset
//   en_i, div_i, lsb_i       run request, SCK half-period minus 1, bit order (1 = LSB first)
//   busy_o                   high while running
//   tx_valid_i/tx_ready_o/tx_data_i           TX sample stream (L, R, L, ...)
//   rx_valid_o/rx_ready_i/rx_data_o/rx_ch_o   RX sample stream and its channel (0 = left)
//   tx_udf_o, rx_ovf_o       one-cycle underrun / overflow pulses
//   i2s_sck_o, i2s_ws_o, i2s_sd_o, i2s_sd_i   I2S bus
`ifndef I2S_DATA_WIDTH
`define I2S_DATA_WIDTH 16
`endif

module i2s_master_core #(
  parameter int unsigned DATA_WIDTH = `I2S_DATA_WIDTH,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  lsb_i,
  output logic                  busy_o,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_ch_o,
  output logic                  tx_udf_o,
  output logic                  rx_ovf_o,
  output logic                  i2s_sck_o,
  output logic                  i2s_ws_o,
  output logic                  i2s_sd_o,
  input  logic                  i2s_sd_i
);

  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic                  sck_q, sck_d, ws_q, ws_d, sd_q, sd_d;
  logic [BitW-1:0]       bit_q, bit_d;       // slot driven at the next fall tick
  logic [BitW-1:0]       last_k_q, last_k_d; // slot sampled at the next rise tick
  logic                  lead_q, lead_d;     // lead-in period: no sampling, no frame exit
  logic                  lsb_q, lsb_d, word_ch_q, word_ch_d;
  logic [DATA_WIDTH-1:0] tx_word_q, tx_word_d, hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d, rx_ch_q, rx_ch_d;
  logic                  udf_q, udf_d, ovf_q, ovf_d;

  logic                  tick, rise, fall, word_start, stop, load_ok, accept, rx_done;
  logic                  cur_lsb;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [BitW-1:0]       tx_idx, rx_idx;

  assign tick       = (state_q == StRun) && (cnt_q == div_q);
  assign rise       = tick && !sck_q;
  assign fall       = tick && sck_q;
  assign word_start = fall && (bit_q == '0);
  // Frame boundary: start of a left word, but never the first word after lead-in.
  assign stop       = word_start && !ws_q && !lead_q && !en_i;
  assign load_ok    = word_start && !stop;
  assign accept     = tx_valid_i && !hold_full_q;

  // Word-start slot uses the value being loaded this cycle, not the stale shift word.
  assign cur_word = word_start ? (hold_full_q ? hold_q : '0) : tx_word_q;
  assign cur_lsb  = word_start ? lsb_i : lsb_q;
  assign tx_idx   = cur_lsb ? bit_q : (LastBit - bit_q);
  assign rx_idx   = lsb_q ? last_k_q : (LastBit - last_k_q);

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (en_i) state_d = StRun;
      StRun:  if (stop) state_d = StIdle;
    endcase
  end

  // FSM / bus outputs
  always_comb begin
    busy_o     = (state_q == StRun);
    tx_ready_o = !hold_full_q;
    rx_valid_o = rx_valid_q;
    rx_data_o  = rx_data_q;
    rx_ch_o    = rx_ch_q;
    tx_udf_o   = udf_q;
    rx_ovf_o   = ovf_q;
    i2s_sck_o  = sck_q;
    i2s_ws_o   = ws_q;
    i2s_sd_o   = sd_q;
  end

  // Datapath next state
  always_comb begin
    div_d       = div_q;
    cnt_d       = cnt_q;
    sck_d       = sck_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    bit_d       = bit_q;
    last_k_d    = last_k_q;
    lead_d      = lead_q;
    lsb_d       = lsb_q;
    word_ch_d   = word_ch_q;
    tx_word_d   = tx_word_q;
    rx_shift_d  = rx_shift_q;
    rx_done     = 1'b0;

    if ((state_q == StIdle) && en_i) begin
      div_d  = div_i;
      cnt_d  = '0;
      sck_d  = 1'b0;
      ws_d   = 1'b0;
      sd_d   = 1'b0;
      bit_d  = '0;
      lead_d = 1'b1;
    end else if (state_q == StRun) begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
      if (tick) sck_d = ~sck_q;
      if (stop) begin
        sd_d = 1'b0;
      end else if (fall) begin
        if (word_start) begin
          tx_word_d = cur_word;
          lsb_d     = lsb_i;
          word_ch_d = ws_q;
          lead_d    = 1'b0;
        end
        sd_d     = cur_word[tx_idx];
        last_k_d = bit_q;
        if (bit_q == LastBit) begin
          bit_d = '0;
          ws_d  = ~ws_q;  // WS leads the next word by one SCK
        end else begin
          bit_d = bit_q + BitW'(1);
        end
      end
      if (rise && !lead_q) begin
        rx_shift_d[rx_idx] = i2s_sd_i;
        rx_done            = (last_k_q == LastBit);
      end
    end

    // TX holding register: accept only when empty, so accept and load never collide.
    hold_d      = accept ? tx_data_i : hold_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_full_d = 1'b1;
    end else if (load_ok && hold_full_q) begin
      hold_full_d = 1'b0;
    end
    udf_d = load_ok && !hold_full_q;

    // RX output register
    rx_data_d  = rx_data_q;
    rx_ch_d    = rx_ch_q;
    rx_valid_d = rx_valid_q;
    ovf_d      = 1'b0;
    if (rx_done) begin
      if (!rx_valid_q || rx_ready_i) begin
        rx_data_d  = rx_shift_d;
        rx_ch_d    = word_ch_q;
        rx_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q       <= '0;
      cnt_q       <= '0;
      sck_q       <= 1'b0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      bit_q       <= '0;
      last_k_q    <= '0;
      lead_q      <= 1'b0;
      lsb_q       <= 1'b0;
      word_ch_q   <= 1'b0;
      tx_word_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ch_q     <= 1'b0;
      udf_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      sck_q       <= sck_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      bit_q       <= bit_d;
      last_k_q    <= last_k_d;
      lead_q      <= lead_d;
      lsb_q       <= lsb_d;
      word_ch_q   <= word_ch_d;
      tx_word_q   <= tx_word_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_ch_q     <= rx_ch_d;
      udf_q       <= udf_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_i2s_master_core.sv
// Self-checking bench for i2s_master_core (DATA_WIDTH = 16).
// A cycle-level reference derived from frame arithmetic (half-period index -> slot -> word/bit)
// checks every output on every falling clk edge; table vectors and directed sequences add
// explicit end-to-end checks.
module tb_i2s_master_core;
  localparam int DW = 16;

  logic          clk_i = 1'b0, rst_n_i = 1'b0, en_i = 1'b0, lsb_i = 1'b0;
  logic [15:0]   div_i = '0;
  logic          tx_valid_i = 1'b0, rx_ready_i = 1'b1;
  logic [DW-1:0] tx_data_i = '0;
  logic          busy_o, tx_ready_o, rx_valid_o, rx_ch_o, tx_udf_o, rx_ovf_o;
  logic [DW-1:0] rx_data_o;
  logic          i2s_sck_o, i2s_ws_o, i2s_sd_o, i2s_sd_i;
  logic          loop_en = 1'b0, sd_rand = 1'b0;

  assign i2s_sd_i = loop_en ? i2s_sd_o : sd_rand;

  i2s_master_core #(.DATA_WIDTH(DW), .DIV_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .div_i(div_i), .lsb_i(lsb_i),
    .busy_o(busy_o), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o), .rx_ch_o(rx_ch_o),
    .tx_udf_o(tx_udf_o), .rx_ovf_o(rx_ovf_o), .i2s_sck_o(i2s_sck_o), .i2s_ws_o(i2s_ws_o),
    .i2s_sd_o(i2s_sd_o), .i2s_sd_i(i2s_sd_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0, n_errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_run = 1'b0, m_lsb = 1'b0, m_rxv = 1'b0, m_rxch = 1'b0;
  bit            m_udf = 1'b0, m_ovf = 1'b0;
  int            m_n = 0, m_h = 1;
  logic [DW-1:0] m_cur = '0, m_rxw = '0, m_rxd = '0;
  logic [DW-1:0] m_txq[$];
  int            mj, ms, mk;
  bit            m_was_empty, m_done, m_done_ch;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_run = 0; m_lsb = 0; m_rxv = 0; m_rxch = 0; m_udf = 0; m_ovf = 0;
      m_n = 0; m_h = 1; m_cur = '0; m_rxw = '0; m_rxd = '0; m_txq.delete();
    end else begin
      m_was_empty = (m_txq.size() == 0);
      m_udf = 0; m_ovf = 0; m_done = 0; m_done_ch = 0;
      if (!m_run) begin
        if (en_i) begin m_run = 1; m_n = 0; m_h = int'(div_i) + 1; end
      end else begin
        if (m_n % m_h == m_h - 1) begin
          mj = m_n / m_h;
          if (mj % 2 == 1) begin
            ms = (mj - 1) / 2;  // slot starting after this fall
            if (ms % DW == 0) begin
              if (ms > 0 && (ms / DW) % 2 == 0 && !en_i) begin
                m_run = 0;
              end else begin
                if (!m_was_empty) m_cur = m_txq.pop_front();
                else begin m_cur = '0; m_udf = 1; end
                m_lsb = lsb_i;
              end
            end
          end else if (mj >= 2) begin
            ms = (mj - 2) / 2;
            mk = ms % DW;
            m_rxw[m_lsb ? mk : DW - 1 - mk] = i2s_sd_i;
            if (mk == DW - 1) begin m_done = 1; m_done_ch = 1'((ms / DW) % 2); end
          end
        end
        m_n++;
      end
      if (tx_valid_i && m_was_empty) m_txq.push_back(tx_data_i);
      if (m_done) begin
        if (!m_rxv || rx_ready_i) begin m_rxd = m_rxw; m_rxch = m_done_ch; m_rxv = 1; end
        else m_ovf = 1;
      end else if (m_rxv && rx_ready_i) begin
        m_rxv = 0;
      end
    end
  end

  int  cj, cs;
  bit  e_sck, e_ws, e_sd;
  always @(negedge clk_i) begin
    if (chk_on) begin
      e_sck = 0; e_ws = 0; e_sd = 0;
      if (m_run) begin
        cj = m_n / m_h;
        e_sck = 1'(cj % 2);
        if (cj >= 2) begin
          cs = (cj - 2) / 2;
          e_ws = 1'(((cs + 1) / DW) % 2);
          e_sd = m_lsb ? m_cur[cs % DW] : m_cur[DW - 1 - cs % DW];
        end
      end
      chk("busy", 32'(busy_o), 32'(m_run));
      chk("sck", 32'(i2s_sck_o), 32'(e_sck));
      chk("ws", 32'(i2s_ws_o), 32'(e_ws));
      chk("sd", 32'(i2s_sd_o), 32'(e_sd));
      chk("tx_ready", 32'(tx_ready_o), 32'(m_txq.size() == 0));
      chk("tx_udf", 32'(tx_udf_o), 32'(m_udf));
      chk("rx_valid", 32'(rx_valid_o), 32'(m_rxv));
      chk("rx_data", 32'(rx_data_o), 32'(m_rxd));
      chk("rx_ch", 32'(rx_ch_o), 32'(m_rxch));
      chk("rx_ovf", 32'(rx_ovf_o), 32'(m_ovf));
    end
  end

  // ---------------- observation counters ----------------
  int busy_cnt = 0, udf_cnt = 0, ovf_cnt = 0, sd1_cnt = 0;
  logic [DW:0] got[$];
  always @(negedge clk_i) begin
    sd_rand = 1'($urandom);
    if (busy_o) busy_cnt++;
    if (tx_udf_o) udf_cnt++;
    if (rx_ovf_o) ovf_cnt++;
    if (busy_o && i2s_sd_o) sd1_cnt++;
    if (rx_valid_o && rx_ready_i) got.push_back({rx_ch_o, rx_data_o});
  end

  // ---------------- helpers ----------------
  task automatic push(input logic [DW-1:0] w);
    int t = 0;
    tx_data_i = w; tx_valid_i = 1'b1;
    while (!tx_ready_o && t < 2000) begin @(negedge clk_i); t++; end
    chk("push_timeout", 32'(tx_ready_o), 32'd1);
    @(negedge clk_i);
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy_o && t < 5000) begin @(negedge clk_i); t++; end
    chk(name, 32'(busy_o), 32'd0);
  endtask

  task automatic clr_cnt();
    busy_cnt = 0; udf_cnt = 0; ovf_cnt = 0; sd1_cnt = 0; got.delete();
  endtask

  typedef struct {
    int            dv;
    bit            lsb;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    bit            first_sd;
    int            busy_cyc;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    div_i = 16'(v.dv); lsb_i = v.lsb;
    clr_cnt();
    push(v.l);
    en_i = 1'b1; @(negedge clk_i); en_i = 1'b0;
    chk($sformatf("v%0d_busy_rise", idx), 32'(busy_o), 32'd1);
    repeat (2 * (v.dv + 1)) @(negedge clk_i);
    chk($sformatf("v%0d_first_sd", idx), 32'(i2s_sd_o), 32'(v.first_sd));
    push(v.r);
    wait_idle($sformatf("v%0d_idle_timeout", idx));
    chk($sformatf("v%0d_busy_len", idx), 32'(busy_cnt), 32'(v.busy_cyc));
    chk($sformatf("v%0d_rx_count", idx), 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      chk($sformatf("v%0d_rx_left", idx), 32'(got[0]), 32'({1'b0, v.l}));
      chk($sformatf("v%0d_rx_right", idx), 32'(got[1]), 32'({1'b1, v.r}));
    end
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{1, 1'b0, 16'hA5F0, 16'h1234, 1'b1, 132};
    tbl[1] = '{0, 1'b1, 16'h0001, 16'h8000, 1'b1, 66};
    tbl[2] = '{3, 1'b0, 16'h0F0F, 16'hF0F0, 1'b0, 264};
    tbl[3] = '{2, 1'b1, 16'h1234, 16'hABCD, 1'b0, 198};

    repeat (3) @(negedge clk_i);
    chk_on = 1'b1;
    chk("rst_tx_ready", 32'(tx_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Loopback vectors
    loop_en = 1'b1; rx_ready_i = 1'b1;
    for (int v = 0; v < 4; v++) run_vec(tbl[v], v);

    // Overflow: two words complete with no RX consumer
    rx_ready_i = 1'b0; div_i = 16'd0; lsb_i = 1'b0;
    clr_cnt();
    push(16'h1111);
    en_i = 1'b1; @(negedge clk_i); en_i = 1'b0;
    push(16'h2222);
    wait_idle("ovf_idle_timeout");
    chk("ovf_pulses", 32'(ovf_cnt), 32'd1);
    chk("ovf_held_valid", 32'(rx_valid_o), 32'd1);
    chk("ovf_held_data", 32'(rx_data_o), 32'h1111);
    chk("ovf_held_ch", 32'(rx_ch_o), 32'd0);
    rx_ready_i = 1'b1; @(negedge clk_i);
    chk("ovf_drained", 32'(rx_valid_o), 32'd0);

    // Underrun: no TX data for a whole frame
    loop_en = 1'b0; div_i = 16'd1;
    clr_cnt();
    en_i = 1'b1; @(negedge clk_i); en_i = 1'b0;
    wait_idle("udf_idle_timeout");
    chk("udf_pulses", 32'(udf_cnt), 32'd2);
    chk("udf_sd_zero", 32'(sd1_cnt), 32'd0);

    // Stop mid-frame: drop en during bit 5 of the second left word
    clr_cnt();
    en_i = 1'b1; @(negedge clk_i);
    repeat (152) @(negedge clk_i);
    en_i = 1'b0;
    wait_idle("stop_idle_timeout");
    chk("stop_busy_len", 32'(busy_cnt), 32'd260);
    chk("stop_sck", 32'(i2s_sck_o), 32'd0);
    chk("stop_ws", 32'(i2s_ws_o), 32'd0);
    chk("stop_sd", 32'(i2s_sd_o), 32'd0);

    // Asynchronous reset mid-frame with the holding register full
    loop_en = 1'b1; div_i = 16'd2;
    push(16'hBEEF);
    en_i = 1'b1; @(negedge clk_i); en_i = 1'b0;
    push(16'hC0DE);
    repeat (40) @(negedge clk_i);
    chk("pre_rst_ready", 32'(tx_ready_o), 32'd0);
    @(posedge clk_i); #2;
    rst_n_i = 1'b0; #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_bus", 32'({i2s_sck_o, i2s_ws_o, i2s_sd_o}), 32'd0);
    chk("arst_tx_ready", 32'(tx_ready_o), 32'd1);
    chk("arst_rx", 32'({rx_valid_o, rx_ch_o, tx_udf_o, rx_ovf_o}), 32'd0);
    chk("arst_rx_data", 32'(rx_data_o), 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Randomised traffic against the reference model
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk_i);
      if ($urandom_range(0, 299) == 0) en_i = ~en_i;
      if ($urandom_range(0, 999) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 39) == 0) lsb_i = ~lsb_i;
      div_i      = 16'($urandom_range(0, 3));
      tx_valid_i = ($urandom_range(0, 3) != 0);
      tx_data_i  = DW'($urandom);
      rx_ready_i = ($urandom_range(0, 3) != 0);
    end
    en_i = 1'b0; tx_valid_i = 1'b0; rx_ready_i = 1'b1;
    @(negedge clk_i);
    wait_idle("rand_idle_timeout");
    repeat (4) @(negedge clk_i);
    chk_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
